rr_encoder_8to3: RTL and testbench

- Sequential 8-to-3 request encoder: the inverse of the register file's 3-to-8 write-select decoder.
- Collects up to eight one-hot-style request lines into a sticky pending register and grants them one at a time in round-robin order.
- Each grant is presented as a 3-bit index with a valid/ready handshake.
- Sits between multiple write sources and the register-file write port; the granted index drives the decoder's ctrl input.

---
 rtl/rr_encoder_8to3.sv | 117 +++++++++++
 tb/tb_rr_encoder_8to3.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_8to3.sv
// Purpose : sticky 8-bit request collector granting one 3-bit index at a time, round-robin
//           (fixed lowest-index priority when RR_ENCODER_FIXED_PRIO_EN is defined).
// Latency : request captured at edge N, earliest grant visible after edge N+1; back-to-back
//           grants every cycle while out_ready stays high.
// Backpressure: out_valid/out_index hold until out_ready; requests keep accumulating meanwhile.
module rr_encoder_8to3 (
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic       Enable,
    input  logic [7:0] req_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_index,
    output logic [7:0] pending,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic       handshake;
    logic [7:0] ack_mask;
    logic [7:0] cand;
    logic       cand_any;
    logic [7:0] pending_next;
    logic [2:0] sel;

    assign handshake    = (state == HOLD) && out_ready;
    assign ack_mask     = handshake ? (8'b1 << out_index) : 8'h00;
    assign pending_next = (pending & ~ack_mask) | (Enable ? req_in : 8'h00);
    assign busy         = (|pending) | out_valid;

    // Bits captured at this edge are not yet in pending, so they can never be selected now.
    always_comb begin
        cand = 8'h00;
        case (state)
            IDLE:    cand = pending;
            HOLD:    cand = out_ready ? (pending & ~ack_mask) : 8'h00;
            default: cand = 8'h00;
        endcase
    end

    assign cand_any = |cand;

`ifdef RR_ENCODER_FIXED_PRIO_EN
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) sel = 3'(i);
        end
    end
`else
    logic [2:0]  ptr;
    logic [15:0] cand_dbl;
    logic [7:0]  cand_rot;
    logic [2:0]  sel_off;

    // Rotate so that bit 0 of cand_rot is request ptr; the lowest set bit is then the winner.
    assign cand_dbl = {cand, cand} >> ptr;
    assign cand_rot = cand_dbl[7:0];

    always_comb begin
        sel_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand_rot[i]) sel_off = 3'(i);
        end
    end

    assign sel = ptr + sel_off;

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            ptr <= 3'd0;
        end else if (handshake) begin
            ptr <= out_index + 3'd1;
        end
    end
`endif

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_index <= 3'd0;
            pending   <= 8'h00;
        end else begin
            pending <= pending_next;
            case (state)
                IDLE: begin
                    if (cand_any) begin
                        out_index <= sel;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (cand_any) begin
                            out_index <= sel;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_encoder_8to3.sv
// Scoreboarded bench for rr_encoder_8to3: directed scenarios followed by randomized traffic,
// compared cycle by cycle against a behavioural grant model.
module tb_rr_encoder_8to3;

    logic       clock;
    logic       ctrl_reset;
    logic       Enable;
    logic [7:0] req_in;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_index;
    logic [7:0] pending;
    logic       busy;

    rr_encoder_8to3 dut (
        .clock     (clock),
        .ctrl_reset(ctrl_reset),
        .Enable    (Enable),
        .req_in    (req_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_index (out_index),
        .pending   (pending),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       vld;
        logic [2:0] idx;
        logic [7:0] pend;
        logic       bsy;
    } snap_t;

    snap_t exp_q[$];
    int    checks  = 0;
    int    errors  = 0;
    bit    started = 0;

    // Reference state: pending set as an integer bitmap, grant flag, granted number, pointer.
    int m_pend = 0;
    bit m_vld  = 0;
    int m_idx  = 0;
    int m_ptr  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit has_req(input int set, input int n);
        return ((set >> n) & 1) == 1;
    endfunction

    task automatic model_step(input bit rst_n, input bit en, input bit [7:0] req, input bit rdy);
        int  cset;
        int  base;
        int  pick;
        int  n;
        bit  hs;
        if (!rst_n) begin
            m_pend = 0;
            m_vld  = 0;
            m_idx  = 0;
            m_ptr  = 0;
            return;
        end
        hs = m_vld && rdy;
        if (!m_vld)   cset = m_pend;
        else if (rdy) cset = m_pend & ~(1 << m_idx);
        else          cset = 0;
`ifdef RR_ENCODER_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        pick = -1;
        for (int k = 0; k < 8; k++) begin
            n = (base + k) % 8;
            if (pick < 0 && has_req(cset, n)) pick = n;
        end
        m_pend = ((m_pend & ~(hs ? (1 << m_idx) : 0)) | (en ? int'(req) : 0)) & 255;
        if (!m_vld) begin
            if (pick >= 0) begin
                m_vld = 1;
                m_idx = pick;
            end
        end else if (rdy) begin
            m_ptr = (m_idx + 1) % 8;
            if (pick >= 0) m_idx = pick;
            else           m_vld = 0;
        end
    endtask

    task automatic cycle(input bit rst_n, input bit en, input bit [7:0] req, input bit rdy);
        snap_t s;
        @(negedge clock);
        ctrl_reset = rst_n;
        Enable     = en;
        req_in     = req;
        out_ready  = rdy;
        if (!rst_n) begin
            #1;
            chk("async_rst_valid",   {31'd0, out_valid}, 32'd0);
            chk("async_rst_pending", {24'd0, pending},   32'd0);
            chk("async_rst_busy",    {31'd0, busy},      32'd0);
        end
        model_step(rst_n, en, req, rdy);
        s.vld  = m_vld;
        s.idx  = 3'(m_idx);
        s.pend = 8'(m_pend);
        s.bsy  = (m_pend != 0) || m_vld;
        exp_q.push_back(s);
        started = 1;
    endtask

    // Directed check of the state right after the edge that the last cycle() drove.
    task automatic after(input string name, input bit vld, input int idx, input int pend);
        @(posedge clock);
        #2;
        chk({name, "_valid"},   {31'd0, out_valid}, {31'd0, vld});
        chk({name, "_pending"}, {24'd0, pending},   32'(pend));
        if (vld) chk({name, "_index"}, {29'd0, out_index}, 32'(idx));
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                if (started) chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                s = exp_q.pop_front();
                chk("sb_valid",   {31'd0, out_valid}, {31'd0, s.vld});
                chk("sb_pending", {24'd0, pending},   {24'd0, s.pend});
                chk("sb_busy",    {31'd0, busy},      {31'd0, s.bsy});
                if (s.vld) chk("sb_index", {29'd0, out_index}, {29'd0, s.idx});
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        ctrl_reset = 1'b0;
        Enable     = 1'b1;
        req_in     = 8'hFF;
        out_ready  = 1'b0;

        // Reset held with all requests asserted.
        repeat (3) cycle(0, 1, 8'hFF, 1);
        chk("rst_index", {29'd0, out_index}, 32'd0);
        after("rst_hold", 0, 0, 8'h00);
        cycle(1, 1, 8'h00, 1);
        cycle(1, 1, 8'h00, 1);
        after("rst_release", 0, 0, 8'h00);

        // Single request.
        cycle(1, 1, 8'h20, 1);
        after("single_capture", 0, 0, 8'h20);
        cycle(1, 1, 8'h00, 1);
        after("single_grant", 1, 5, 8'h20);
        cycle(1, 1, 8'h00, 1);
        after("single_done", 0, 0, 8'h00);

        // Back-to-back round robin from a fresh pointer.
        cycle(0, 1, 8'h00, 0);
        cycle(1, 1, 8'h91, 1);
        cycle(1, 1, 8'h00, 1);
        after("rr_g0", 1, 0, 8'h91);
        cycle(1, 1, 8'h00, 1);
        after("rr_g4", 1, 4, 8'h90);
        cycle(1, 1, 8'h00, 1);
        after("rr_g7", 1, 7, 8'h80);
        cycle(1, 1, 8'h00, 1);
        after("rr_idle", 0, 0, 8'h00);
        // Pointer wrapped back to 0 after granting 7, so 0 is searched first.
        cycle(1, 1, 8'h11, 1);
        cycle(1, 1, 8'h00, 1);
        after("wrap_first", 1, 0, 8'h11);
        cycle(1, 1, 8'h00, 1);
        after("wrap_second", 1, 4, 8'h10);
        cycle(1, 1, 8'h00, 1);

        // Stall on grant 3 with a new request arriving, then set-wins on the acked bit.
        cycle(1, 1, 8'h08, 0);
        cycle(1, 1, 8'h04, 0);
        repeat (3) cycle(1, 1, 8'h04, 0);
        after("stall_hold", 1, 3, 8'h0C);
        cycle(1, 1, 8'h08, 1);
        after("set_wins", 1, 2, 8'h0C);

        // Enable gating: capture blocked, grant still completes.
        cycle(1, 0, 8'hFF, 0);
        after("en_block", 1, 2, 8'h0C);
        cycle(1, 0, 8'hFF, 1);
        after("en_grant", 1, 3, 8'h08);
        cycle(1, 0, 8'h00, 1);
        after("en_drain", 0, 0, 8'h00);

        // Asynchronous reset while a grant is outstanding.
        cycle(1, 1, 8'h06, 0);
        cycle(1, 1, 8'h00, 0);
        after("pre_rst", 1, 1, 8'h06);
        cycle(0, 1, 8'h06, 1);
        cycle(1, 1, 8'h00, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                  8'($urandom & $urandom), ($urandom_range(0, 2) != 0));
        end

        @(posedge clock);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
